// File: rtl/module_div_ctrl_if.sv
// Bus between the keypad/button front end, the division sequencer
// and the display mux.
interface module_div_ctrl_if #(
  parameter int W = 7
) ();
  logic         press;
  logic [W-1:0] data_in;
  logic [1:0]   y_AB;
  logic         y_disp;
  logic         reset_2;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  modport master (
    output press, data_in,
    input  y_AB, y_disp, reset_2, busy, done,
    input  div_by_zero, quotient, remainder
  );

  modport slave (
    input  press, data_in,
    output y_AB, y_disp, reset_2, busy, done,
    output div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/module_div_ctrl.sv
// Operand entry sequencer and W-cycle restoring divider.
// Walks INICIO -> PRIMERO -> SEGUNDO -> DIVIDIR -> MOSTRAR -> LIMPIAR.
module module_div_ctrl #(
  parameter int W = 7
) (
  input  logic clk,
  input  logic reset,
  module_div_ctrl_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [2:0] {
    INICIO, PRIMERO, SEGUNDO,
    DIVIDIR, MOSTRAR, LIMPIAR
  } state_t;

  state_t        state_q, state_d;
  logic          press_q, press_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  remd_q, remd_d;
  logic          dbz_q, dbz_d;
  logic          done_q, done_d;

  logic          evt;
  logic [W:0]    t;
  logic [W:0]    t_sub;
  logic          t_ge;
  logic [W-1:0]  step_rem;
  logic [W-1:0]  step_q;

  assign evt      = bus.press & ~press_q;
  assign t        = {rem_q, q_q[W-1]};
  assign t_sub    = t - {1'b0, b_q};
  assign t_ge     = (t >= {1'b0, b_q});
  assign step_rem = t_ge ? t_sub[W-1:0] : t[W-1:0];
  assign step_q   = {q_q[W-2:0], t_ge};

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= INICIO;
      press_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  // Next state, operand capture and division steps
  always_comb begin
    state_d = state_q;
    press_d = bus.press;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      INICIO: begin
        if (evt) state_d = PRIMERO;
      end
      PRIMERO: begin
        if (evt) begin
          a_d     = bus.data_in;
          state_d = SEGUNDO;
        end
      end
      SEGUNDO: begin
        if (evt) begin
          b_d     = bus.data_in;
          rem_d   = '0;
          q_d     = a_q;
          cnt_d   = '0;
          state_d = DIVIDIR;
        end
      end
      DIVIDIR: begin
        if (b_q == '0) begin
          dbz_d   = 1'b1;
          quot_d  = '1;
          remd_d  = a_q;
          done_d  = 1'b1;
          state_d = MOSTRAR;
        end else begin
          rem_d = step_rem;
          q_d   = step_q;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            quot_d  = step_q;
            remd_d  = step_rem;
            done_d  = 1'b1;
            state_d = MOSTRAR;
          end
        end
      end
      MOSTRAR: begin
        if (evt) begin
          a_d     = '0;
          b_d     = '0;
          quot_d  = '0;
          remd_d  = '0;
          dbz_d   = 1'b0;
          state_d = LIMPIAR;
        end
      end
      LIMPIAR: begin
        state_d = INICIO;
      end
      default: state_d = INICIO;
    endcase
  end

  // Moore decode of display select and status strobes
  always_comb begin
    bus.y_AB    = 2'b00;
    bus.y_disp  = 1'b0;
    bus.busy    = 1'b0;
    bus.reset_2 = 1'b0;
    unique case (state_q)
      INICIO:  bus.y_AB = 2'b00;
      PRIMERO: bus.y_AB = 2'b01;
      SEGUNDO: bus.y_AB = 2'b10;
      DIVIDIR: begin
        bus.y_AB = 2'b11;
        bus.busy = 1'b1;
      end
      MOSTRAR: begin
        bus.y_AB   = 2'b11;
        bus.y_disp = 1'b1;
      end
      LIMPIAR: bus.reset_2 = 1'b1;
      default: bus.y_AB = 2'b00;
    endcase
  end

  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remd_q;
endmodule

// File: tb/tb_module_div_ctrl.sv
// Directed bench for module_div_ctrl: reset, held press,
// normal divide, divide by zero, ignored press, mid-divide reset.
module tb_module_div_ctrl;
  localparam int W = 7;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  module_div_ctrl_if #(.W(W)) bus ();

  module_div_ctrl #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.press = 1'b1;
    tick();
    bus.press = 1'b0;
    tick();
  endtask

  // Starts in PRIMERO; enters A and B, then watches busy/done.
  task automatic do_div(input int a, input int b,
                        input int eq, input int er,
                        input int ez, input int nb_exp,
                        input bit mid_press);
    int nb;
    int nd;
    int di;
    nb = 0;
    nd = 0;
    di = -1;
    bus.data_in = W'(a);
    pulse();
    chk("y_AB_seg", 32'(bus.y_AB), 2);
    bus.data_in = W'(b);
    bus.press = 1'b1;
    tick();
    bus.press = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (bus.busy) nb++;
      if (bus.done) begin
        nd++;
        di = i;
      end
      if (mid_press) bus.press = (i == 2);
      tick();
    end
    bus.press = 1'b0;
    chk("busy_cycles", 32'(nb), 32'(nb_exp));
    chk("done_count", 32'(nd), 1);
    chk("done_pos", 32'(di), 32'(nb_exp));
    chk("quotient", 32'(bus.quotient), 32'(eq));
    chk("remainder", 32'(bus.remainder), 32'(er));
    chk("dbz", 32'(bus.div_by_zero), 32'(ez));
    chk("y_AB_res", 32'(bus.y_AB), 3);
    chk("y_disp_res", 32'(bus.y_disp), 1);
  endtask

  task automatic do_clear();
    bus.press = 1'b1;
    tick();
    bus.press = 1'b0;
    chk("reset_2_on", 32'(bus.reset_2), 1);
    chk("y_disp_clr", 32'(bus.y_disp), 0);
    tick();
    chk("reset_2_off", 32'(bus.reset_2), 0);
    chk("y_AB_idle", 32'(bus.y_AB), 0);
    chk("quot_clr", 32'(bus.quotient), 0);
    chk("rem_clr", 32'(bus.remainder), 0);
    chk("dbz_clr", 32'(bus.div_by_zero), 0);
  endtask

  initial begin
    int nd;
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.press = 1'b1;
    bus.data_in = '0;
    tick();
    tick();
    chk("rst_y_AB", 32'(bus.y_AB), 0);
    chk("rst_y_disp", 32'(bus.y_disp), 0);
    chk("rst_reset_2", 32'(bus.reset_2), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_dbz", 32'(bus.div_by_zero), 0);
    chk("rst_quot", 32'(bus.quotient), 0);
    chk("rst_rem", 32'(bus.remainder), 0);

    // Press still high at release: one event, then held
    reset = 1'b1;
    bus.data_in = W'(33);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_y_AB", 32'(bus.y_AB), 1);
    end
    bus.press = 1'b0;
    tick();
    chk("held_after", 32'(bus.y_AB), 1);

    do_div(99, 7, 14, 1, 0, 7, 1'b0);
    do_clear();

    pulse();
    chk("y_AB_pri", 32'(bus.y_AB), 1);
    do_div(45, 0, 127, 45, 1, 1, 1'b0);
    do_clear();

    pulse();
    do_div(50, 8, 6, 2, 0, 7, 1'b1);
    do_clear();

    // Reset before the third step edge abandons the divide
    pulse();
    bus.data_in = W'(99);
    pulse();
    bus.data_in = W'(7);
    bus.press = 1'b1;
    tick();
    bus.press = 1'b0;
    tick();
    tick();
    chk("mid_busy_pre", 32'(bus.busy), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_y_AB", 32'(bus.y_AB), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_quot", 32'(bus.quotient), 0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) nd++;
      tick();
    end
    chk("mid_no_done", 32'(nd), 0);
    chk("mid_idle", 32'(bus.y_AB), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
